// File: rtl/uc_link_pkg.sv
// Shared framing constants and state encoding for the microcontroller serial link.
// Frame = sync header, two data words MSB first, even parity over the data bits.
package uc_link_pkg;

  localparam logic [3:0] SYNC_HDR = 4'b1010;
  localparam int         HDR_LEN  = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  function automatic int frame_bits(input int datlen);
    return HDR_LEN + 2 * datlen + 1;
  endfunction

endpackage

// File: rtl/uc_tx_if.sv
// Parallel load handshake plus framed serial outputs between the peak picker and uc_tx.
// Words are declared [0:DATLEN-1] so index 0 is the first (most significant) bit sent.
interface uc_tx_if #(
  parameter int DATLEN = 12
);
  logic              load;
  logic [0:DATLEN-1] max730;
  logic [0:DATLEN-1] max850;
  logic              ready;
  logic              done;
  logic              frame_n;
  logic              sclk_out;
  logic              sdata_out;

  modport master (
    output load, max730, max850,
    input  ready, done, frame_n, sclk_out, sdata_out
  );

  modport slave (
    input  load, max730, max850,
    output ready, done, frame_n, sclk_out, sdata_out
  );
endinterface

// File: rtl/uc_bit_timer.sv
// Bit period timer: registered sclk (low half then high half) and a period-end strobe.
// Holds phase 0 and sclk low whenever run_i is low; no backpressure.
module uc_bit_timer #(
  parameter int CLKDIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run_i,
  output logic sclk_o,
  output logic period_end_o
);

  localparam int            PW    = $clog2(CLKDIV);
  localparam logic [PW-1:0] LAST  = PW'(CLKDIV - 1);
  localparam logic [PW-1:0] HALF  = PW'(CLKDIV / 2);

  logic [PW-1:0] phase_q, phase_d;
  logic          sclk_q, sclk_d;

  always_comb begin
    phase_d = '0;
    sclk_d  = 1'b0;
    if (run_i) begin
      phase_d = (phase_q == LAST) ? '0 : phase_q + 1'b1;
      // sclk is registered from the next phase so it lines up with the phase it describes
      sclk_d  = (phase_d >= HALF);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= '0;
      sclk_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      sclk_q  <= sclk_d;
    end
  end

  assign sclk_o       = sclk_q;
  assign period_end_o = run_i && (phase_q == LAST);

endmodule

// File: rtl/uc_tx.sv
// Sends max730/max850 to the microcontroller as a framed synchronous serial stream.
// Load accepted only while ready; frame starts the next cycle; GAP_CYC idle cycles follow each frame.
module uc_tx
  import uc_link_pkg::*;
#(
  parameter int DATLEN  = 12,
  parameter int CLKDIV  = 4,
  parameter int GAP_CYC = 8
) (
  input  logic     clk,
  input  logic     reset_n,
  uc_tx_if.slave   bus
);

  localparam int            FB       = frame_bits(DATLEN);
  localparam int            BW       = $clog2(2 * DATLEN + 5);
  localparam int            GW       = $clog2(GAP_CYC + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FB - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [FB-1:0] shreg_q, shreg_d;
  logic          sdata_q, sdata_d;
  logic          frame_n_q, frame_n_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;

  logic [FB-1:0] frame_w;
  logic          period_end;
  logic          sclk;

  assign frame_w = {SYNC_HDR, bus.max730, bus.max850, ^{bus.max730, bus.max850}};

  uc_bit_timer #(
    .CLKDIV (CLKDIV)
  ) u_timer (
    .clk          (clk),
    .reset_n      (reset_n),
    .run_i        (state_q == ST_SHIFT),
    .sclk_o       (sclk),
    .period_end_o (period_end)
  );

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    gap_d     = gap_q;
    shreg_d   = shreg_q;
    sdata_d   = sdata_q;
    frame_n_d = frame_n_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.load && ready_q) begin
          state_d   = ST_SHIFT;
          shreg_d   = frame_w << 1;
          sdata_d   = frame_w[FB-1];
          frame_n_d = 1'b0;
          ready_d   = 1'b0;
          bit_d     = '0;
        end
      end
      ST_SHIFT: begin
        if (period_end) begin
          if (bit_q == BIT_LAST) begin
            state_d   = ST_GAP;
            frame_n_d = 1'b1;
            sdata_d   = 1'b0;
            done_d    = 1'b1;
            bit_d     = '0;
            gap_d     = '0;
          end else begin
            bit_d     = bit_q + 1'b1;
            sdata_d   = shreg_q[FB-1];
            shreg_d   = shreg_q << 1;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
          gap_d   = '0;
        end else begin
          gap_d   = gap_q + 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        ready_d   = 1'b1;
        frame_n_d = 1'b1;
        sdata_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      bit_q     <= '0;
      gap_q     <= '0;
      shreg_q   <= '0;
      sdata_q   <= 1'b0;
      frame_n_q <= 1'b1;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      gap_q     <= gap_d;
      shreg_q   <= shreg_d;
      sdata_q   <= sdata_d;
      frame_n_q <= frame_n_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.done      = done_q;
  assign bus.frame_n   = frame_n_q;
  assign bus.sclk_out  = sclk;
  assign bus.sdata_out = sdata_q;

endmodule

// File: doc/uc_tx.md
Name: uc_tx

Overview:
Serial transmitter that sends the spectral maxima (max730, max850) from the DSP path to the microcontroller. It is the outbound counterpart of the ADC serial reader: it captures two parallel words with a ready/load handshake and shifts them out as a framed synchronous serial stream (frame strobe, bit clock, data). It sits at the tail of process, after peak picking.

Parameters:
DATLEN, 12, width of each transmitted word
CLKDIV, 4, clk cycles per serial bit period; even, >= 2
GAP_CYC, 8, idle clk cycles with frame_n high between frames; >= 1

Ports:
clk  in  1  system clock; all logic on posedge clk
reset_n  in  1  asynchronous active-low reset
load  in  1  request to send; accepted only when ready=1
max730  in  DATLEN  first word, declared [0:DATLEN-1], bit 0 = MSB
max850  in  DATLEN  second word, same ordering
ready  out  1  high when idle and able to accept load
done  out  1  one-cycle pulse when a frame completes
frame_n  out  1  active-low frame strobe to microcontroller
sclk_out  out  1  serial bit clock, idles low
sdata_out  out  1  serial data, idles low

Behaviour:
- Reset (async, immediate): ready=1, done=0, frame_n=1, sclk_out=0, sdata_out=0, state IDLE, counters cleared. All outputs registered.
- Frame format, 29 bits for DATLEN=12 (4+2*DATLEN+1): sync header 1,0,1,0; max730 bit 0..DATLEN-1; max850 bit 0..DATLEN-1; parity bit = XOR of the 2*DATLEN data bits (even parity over data, header excluded).
- Handshake: load && ready at edge N captures both words into a shift register; ready=0 from N+1. load while ready=0 is ignored; inputs are not re-sampled mid-frame.
- States: IDLE -> SHIFT (on accepted load) -> GAP (after last bit period) -> IDLE (after GAP_CYC cycles).
- SHIFT: at N+1 frame_n=0 and sdata_out = first header bit. Each bit period is CLKDIV cycles: sclk_out low for CLKDIV/2 cycles, then high for CLKDIV/2. sdata_out changes only at the start of a period (sclk low); the receiver samples on sclk rising edge.
- End of frame: on the cycle after the last bit period's final high cycle: frame_n=1, sclk_out=0, sdata_out=0, done=1 for exactly that cycle, enter GAP. frame_n is low for exactly 29*CLKDIV cycles (116 at defaults).
- GAP: GAP_CYC cycles with ready=0, then ready=1. load held continuously yields frames separated by GAP_CYC+1 cycles of frame_n high.
- Counters: bit counter sized for 2*DATLEN+5 values, phase counter for CLKDIV; no wrap beyond frame length.
- Reset mid-frame: frame aborts, outputs return to reset values asynchronously; no done pulse; next frame after release is complete and correct.

Decomposition:
- Shared package uc_link_pkg: SYNC_HDR = 4'b1010, HDR_LEN = 4, frame_bits(DATLEN) = HDR_LEN+2*DATLEN+1, state encoding (IDLE, SHIFT, GAP).
- One sub-module natural: uc_bit_timer (phase counter producing sclk level, bit-start strobe, period-end strobe from CLKDIV); uc_tx holds FSM, shift register, parity.

Test Plan:
- max730=12'hABC, max850=12'h123, load 1 cycle -> sampled on sclk rises: 1010 101010111100 000100100011 1 (parity 1, 11 data ones); frame_n low 116 cycles; done one pulse.
- max730=0, max850=0 -> 1010 followed by 25 zeros; parity 0; ready returns 1 exactly GAP_CYC cycles after done.
- load pulsed at bit 5 of a frame with different data -> ignored; transmitted frame unchanged; ready stays 0 until GAP ends.
- reset_n low at bit 10 -> frame_n=1, sclk_out=0, sdata_out=0, ready=1 without waiting for clk; no done; after release, load 12'hFFF/12'hFFF -> 1010, 24 ones, parity 0.
- load held high, words 12'h001/12'h800 -> two complete identical frames, frame_n high 9 cycles between them (GAP_CYC=8).
- CLKDIV=2 build -> sclk_out toggles every cycle in SHIFT; frame_n low 58 cycles; bit stream matches first scenario.
